// File: rtl/sseg_pkg.sv
// Shared 7-segment constants and FSM states for the display driver/capture path.
// Patterns are 7-bit, MSB = segment a ... LSB = segment g, active-low.
package sseg_pkg;

  localparam logic [6:0] SSEG_0 = 7'b0000001;
  localparam logic [6:0] SSEG_1 = 7'b1001111;
  localparam logic [6:0] SSEG_2 = 7'b0010010;
  localparam logic [6:0] SSEG_3 = 7'b0000110;
  localparam logic [6:0] SSEG_4 = 7'b1001100;
  localparam logic [6:0] SSEG_5 = 7'b0100100;
  localparam logic [6:0] SSEG_6 = 7'b0100000;
  localparam logic [6:0] SSEG_7 = 7'b0001111;
  localparam logic [6:0] SSEG_8 = 7'b0000000;
  localparam logic [6:0] SSEG_9 = 7'b0000100;
  localparam logic [6:0] SSEG_A = 7'b0001000;
  localparam logic [6:0] SSEG_B = 7'b1100000;
  localparam logic [6:0] SSEG_C = 7'b0110001;
  localparam logic [6:0] SSEG_D = 7'b1000010;
  localparam logic [6:0] SSEG_E = 7'b0110000;
  localparam logic [6:0] SSEG_F = 7'b0111000;

  localparam logic [6:0] SSEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_COUNT = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Returns {valid, index}; valid only when exactly one anode is driven low.
  function automatic logic [2:0] anode_sel(input logic [3:0] an);
    case (an)
      4'b1110: return 3'b100;
      4'b1101: return 3'b101;
      4'b1011: return 3'b110;
      4'b0111: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/sseg_to_hex.sv
// Combinational segment-pattern to hex-nibble decoder; unknown patterns flag err.
module sseg_to_hex
  import sseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    nibble = 4'h0;
    err    = 1'b0;
    case (seg)
      SSEG_0: nibble = 4'h0;
      SSEG_1: nibble = 4'h1;
      SSEG_2: nibble = 4'h2;
      SSEG_3: nibble = 4'h3;
      SSEG_4: nibble = 4'h4;
      SSEG_5: nibble = 4'h5;
      SSEG_6: nibble = 4'h6;
      SSEG_7: nibble = 4'h7;
      SSEG_8: nibble = 4'h8;
      SSEG_9: nibble = 4'h9;
      SSEG_A: nibble = 4'hA;
      SSEG_B: nibble = 4'hB;
      SSEG_C: nibble = 4'hC;
      SSEG_D: nibble = 4'hD;
      SSEG_E: nibble = 4'hE;
      SSEG_F: nibble = 4'hF;
      SSEG_BLANK: err = 1'b1;
      default:    err = 1'b1;
    endcase
  end

endmodule

// File: rtl/sseg_scan_capture.sv
// Reconstructs the 4 hex digits shown on a multiplexed 7-segment bus and publishes frames.
// Optional macro SSEG_DP_EN adds decimal-point capture (dp_in / dp_out).
module sseg_scan_capture
  import sseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  sseg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] digits_out,
  output logic [3:0]  err_out,
  output logic        frame_valid,
  output logic [3:0]  seen_out
`ifdef SSEG_DP_EN
  ,
  input  logic        dp_in,
  output logic [3:0]  dp_out
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 2);

`ifdef SSEG_DP_EN
  localparam int SW = 12;
`else
  localparam int SW = 11;
`endif

  logic [SW-1:0]    cur;
  logic [SW-1:0]    samp;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  state_t           state_nxt;
  logic             same;
  logic             capture;
  logic             do_cap;
  logic             publish;
  logic [2:0]       sel;
  logic [1:0]       sel_idx;
  logic [3:0]       sel_bit;
  logic [3:0]       nib;
  logic             nib_err;
  logic [15:0]      work_digits;
  logic [15:0]      digits_nxt;
  logic [3:0]       work_err;
  logic [3:0]       err_nxt;

`ifdef SSEG_DP_EN
  logic [3:0] work_dp;
  logic [3:0] dp_nxt;
  assign cur = {dp_in, an_in, sseg_in};
`else
  assign cur = {an_in, sseg_in};
`endif

  assign same    = (cur == samp);
  assign sel     = anode_sel(samp[10:7]);
  assign sel_idx = sel[1:0];
  assign sel_bit = 4'b0001 << sel_idx;
  assign do_cap  = capture & sel[2];
  assign publish = do_cap & ((seen_out | sel_bit) == 4'hF);

  sseg_to_hex u_dec (
    .seg    (samp[6:0]),
    .nibble (nib),
    .err    (nib_err)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_COUNT;
    else     state <= state_nxt;
  end

  // A capture fires on the edge the run counter would reach its terminal value.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    if (!same) begin
      state_nxt = ST_COUNT;
    end else begin
      case (state)
        ST_COUNT: begin
          if (cnt == CNT_ARM) begin
            capture   = 1'b1;
            state_nxt = ST_HOLD;
          end
        end
        ST_HOLD:  state_nxt = ST_HOLD;
        default:  state_nxt = ST_COUNT;
      endcase
    end
  end

  always_comb begin
    digits_nxt = work_digits;
    err_nxt    = work_err;
    digits_nxt[{sel_idx, 2'b00} +: 4] = nib;
    err_nxt[sel_idx] = nib_err;
`ifdef SSEG_DP_EN
    dp_nxt = work_dp;
    dp_nxt[sel_idx] = ~samp[11];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp        <= '0;
      cnt         <= '0;
      seen_out    <= '0;
      work_digits <= '0;
      work_err    <= '0;
      digits_out  <= '0;
      err_out     <= '0;
      frame_valid <= 1'b0;
    end else begin
      samp        <= cur;
      frame_valid <= publish;
      if (!same)               cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      if (do_cap) begin
        work_digits <= digits_nxt;
        work_err    <= err_nxt;
        if (publish) begin
          digits_out <= digits_nxt;
          err_out    <= err_nxt;
          seen_out   <= '0;
        end else begin
          seen_out <= seen_out | sel_bit;
        end
      end
    end
  end

`ifdef SSEG_DP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      work_dp <= '0;
      dp_out  <= '0;
    end else if (do_cap) begin
      work_dp <= dp_nxt;
      if (publish) dp_out <= dp_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Self-checking bench for sseg_scan_capture: directed dwell table, reset and
// fast-toggle sequences, then random dwells against a run-length reference model.
module tb_sseg_scan_capture;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  sseg_in;
  logic [3:0]  an_in;
  logic [15:0] digits_out;
  logic [3:0]  err_out;
  logic        frame_valid;
  logic [3:0]  seen_out;
`ifdef SSEG_DP_EN
  logic        dp_in = 1'b1;
  logic [3:0]  dp_out;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sseg_scan_capture #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .sseg_in     (sseg_in),
    .an_in       (an_in),
    .digits_out  (digits_out),
    .err_out     (err_out),
    .frame_valid (frame_valid),
    .seen_out    (seen_out)
`ifdef SSEG_DP_EN
    ,
    .dp_in       (dp_in),
    .dp_out      (dp_out)
`endif
  );

  logic [6:0] refPat [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Reference model: a dwell is captured when its run length reaches STABLE.
  logic [10:0] mPrev;
  int          mRun;
  logic [3:0]  mSeen;
  logic [3:0]  mWork [4];
  logic [3:0]  mWerr;
  logic [15:0] mDout;
  logic [3:0]  mEout;
  logic        mFv;
  logic        fvSeen;

  typedef struct packed {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [7:0]  cycles;
    logic [3:0]  seen;
    logic        fv;
    logic [15:0] dig;
    logic [3:0]  err;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(input logic [3:0] an, input logic [6:0] seg, input logic [7:0] n,
                              input logic [3:0] seen, input logic fv, input logic [15:0] dig,
                              input logic [3:0] err);
    vec_t v;
    v.an = an; v.seg = seg; v.cycles = n; v.seen = seen; v.fv = fv; v.dig = dig; v.err = err;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPrev = '0;
    mRun  = 1;
    mSeen = '0;
    mWerr = '0;
    mDout = '0;
    mEout = '0;
    mFv   = 1'b0;
    for (int i = 0; i < 4; i++) mWork[i] = '0;
  endtask

  task automatic modelEdge();
    int zeros;
    int idx;
    logic found;
    logic [3:0] val;
    if (rst) begin
      modelReset();
    end else begin
      mFv = 1'b0;
      if ({an_in, sseg_in} == mPrev) mRun++;
      else mRun = 1;
      mPrev = {an_in, sseg_in};
      if (mRun == STABLE) begin
        zeros = 0;
        idx   = 0;
        for (int i = 0; i < 4; i++) if (!an_in[i]) begin zeros++; idx = i; end
        if (zeros == 1) begin
          found = 1'b0;
          val   = 4'h0;
          for (int p = 0; p < 16; p++) if (refPat[p] == sseg_in) begin found = 1'b1; val = 4'(p); end
          mWork[idx] = val;
          mWerr[idx] = !found;
          if ((mSeen | (4'b0001 << idx)) == 4'hF) begin
            mDout = {mWork[3], mWork[2], mWork[1], mWork[0]};
            mEout = mWerr;
            mFv   = 1'b1;
            mSeen = '0;
          end else begin
            mSeen[idx] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    if (frame_valid) fvSeen = 1'b1;
    checkOutput("m_digits", 32'(digits_out), 32'(mDout));
    checkOutput("m_err", 32'(err_out), 32'(mEout));
    checkOutput("m_fv", 32'(frame_valid), 32'(mFv));
    checkOutput("m_seen", 32'(seen_out), 32'(mSeen));
  endtask

  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_in   = an;
    sseg_in = seg;
    repeat (n) tick();
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] ran;
    logic [6:0] rseg;
    int         rn;
    int         rsel;

    vecs[0]  = mk(4'b1110, 7'b0000001, 4,  4'b0001, 0, 16'h0000, 4'b0000);
    vecs[1]  = mk(4'b1101, 7'b0100100, 4,  4'b0011, 0, 16'h0000, 4'b0000);
    vecs[2]  = mk(4'b1011, 7'b0000100, 4,  4'b0111, 0, 16'h0000, 4'b0000);
    vecs[3]  = mk(4'b0111, 7'b0001000, 4,  4'b0000, 1, 16'hA950, 4'b0000);
    vecs[4]  = mk(4'b1110, 7'b0000001, 4,  4'b0001, 0, 16'hA950, 4'b0000);
    vecs[5]  = mk(4'b1101, 7'b0100100, 4,  4'b0011, 0, 16'hA950, 4'b0000);
    vecs[6]  = mk(4'b1011, 7'b0000100, 3,  4'b0011, 0, 16'hA950, 4'b0000);
    vecs[7]  = mk(4'b0111, 7'b0001000, 4,  4'b1011, 0, 16'hA950, 4'b0000);
    vecs[8]  = mk(4'b1011, 7'b0000100, 4,  4'b0000, 1, 16'hA950, 4'b0000);
    vecs[9]  = mk(4'b1110, 7'b0000001, 4,  4'b0001, 0, 16'hA950, 4'b0000);
    vecs[10] = mk(4'b1101, 7'b1111111, 4,  4'b0011, 0, 16'hA950, 4'b0000);
    vecs[11] = mk(4'b1011, 7'b1001111, 4,  4'b0111, 0, 16'hA950, 4'b0000);
    vecs[12] = mk(4'b0111, 7'b0001111, 4,  4'b0000, 1, 16'h7100, 4'b0010);
    vecs[13] = mk(4'b1110, 7'b0110000, 4,  4'b0001, 0, 16'h7100, 4'b0010);
    vecs[14] = mk(4'b1100, 7'b0000000, 10, 4'b0001, 0, 16'h7100, 4'b0010);
    vecs[15] = mk(4'b1111, 7'b0000000, 10, 4'b0001, 0, 16'h7100, 4'b0010);
    vecs[16] = mk(4'b1101, 7'b1100000, 20, 4'b0011, 0, 16'h7100, 4'b0010);
    vecs[17] = mk(4'b1111, 7'b1111111, 1,  4'b0011, 0, 16'h7100, 4'b0010);
    vecs[18] = mk(4'b1101, 7'b1100000, 4,  4'b0011, 0, 16'h7100, 4'b0010);
    vecs[19] = mk(4'b1101, 7'b0110001, 4,  4'b0011, 0, 16'h7100, 4'b0010);
    vecs[20] = mk(4'b1011, 7'b1000010, 4,  4'b0111, 0, 16'h7100, 4'b0010);
    vecs[21] = mk(4'b0111, 7'b0111000, 4,  4'b0000, 1, 16'hFDCE, 4'b0000);

    rst     = 1'b1;
    an_in   = 4'hF;
    sseg_in = 7'h7F;
    fvSeen  = 1'b0;
    modelReset();
    tick();
    tick();
    checkOutput("rst_digits", 32'(digits_out), 32'h0);
    checkOutput("rst_err", 32'(err_out), 32'h0);
    checkOutput("rst_fv", 32'(frame_valid), 32'h0);
    checkOutput("rst_seen", 32'(seen_out), 32'h0);
    rst = 1'b0;

    for (int v = 0; v < 22; v++) begin
      fvSeen = 1'b0;
      applyStimulus(vecs[v].an, vecs[v].seg, int'(vecs[v].cycles));
      checkOutput($sformatf("v%0d_seen", v), 32'(seen_out), 32'(vecs[v].seen));
      checkOutput($sformatf("v%0d_fv", v), 32'(fvSeen), 32'(vecs[v].fv));
      checkOutput($sformatf("v%0d_digits", v), 32'(digits_out), 32'(vecs[v].dig));
      checkOutput($sformatf("v%0d_err", v), 32'(err_out), 32'(vecs[v].err));
    end

    applyStimulus(4'b1110, 7'b1001111, 4);
    applyStimulus(4'b1101, 7'b0010010, 4);
    checkOutput("pre_rst_seen", 32'(seen_out), 32'h3);
    pulseReset();
    checkOutput("post_rst_seen", 32'(seen_out), 32'h0);
    checkOutput("post_rst_digits", 32'(digits_out), 32'h0);
    checkOutput("post_rst_err", 32'(err_out), 32'h0);
    fvSeen = 1'b0;
    applyStimulus(4'b1110, 7'b1001111, 4);
    applyStimulus(4'b1101, 7'b0010010, 4);
    applyStimulus(4'b1011, 7'b0000110, 4);
    applyStimulus(4'b0111, 7'b1001100, 4);
    checkOutput("after_rst_fv", 32'(fvSeen), 32'h1);
    checkOutput("after_rst_digits", 32'(digits_out), 32'h4321);
    checkOutput("after_rst_err", 32'(err_out), 32'h0);

    applyStimulus(4'b1110, 7'b0110000, 4);
    fvSeen = 1'b0;
    for (int k = 0; k < 24; k++) begin
      rseg = refPat[$urandom_range(0, 15)];
      applyStimulus((k % 2 == 0) ? 4'b1101 : 4'b1011, rseg, 1);
    end
    checkOutput("toggle_seen", 32'(seen_out), 32'h1);
    checkOutput("toggle_fv", 32'(fvSeen), 32'h0);

    for (int d = 0; d < 300; d++) begin
      rsel = $urandom_range(0, 9);
      if (rsel < 6)      ran = ~(4'b0001 << $urandom_range(0, 3));
      else if (rsel < 8) ran = 4'b1111;
      else               ran = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rseg = 7'($urandom_range(0, 127));
      else                           rseg = refPat[$urandom_range(0, 15)];
      rn = $urandom_range(1, 8);
      applyStimulus(ran, rseg, rn);
      if (d % 97 == 50) pulseReset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
